object_stats_reader: RTL and testbench

Back-end reader for the connected-components statistics port. After a frame has been labelled, it walks `obj_id` from 1 to `num_labels`, waits out the statistics read latency, captures the ten per-object values and streams them out one word at a time over a valid/ready handshake. It sits beside the detection top level, driving its `obj_id` input and consuming `num_labels`, `obj_area`, `obj_x`, `obj_y` and `obj_m*`. Its output stream is the one the host/UART path drains.

---
 rtl/object_stats_reader.sv | 146 ++++++++++++++
 tb/tb_object_stats_reader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_stats_reader.sv
// Walks labels 1..n_max, waits out the statistics read latency, snapshots the ten
// per-object values and streams them one word per valid/ready handshake.
module object_stats_reader #(
  parameter int LBL_WIDTH    = 8,
  parameter int LOC_SIZE     = 16,
  parameter int READ_LATENCY = 2,
  parameter int SKIP_EMPTY   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LBL_WIDTH-1:0] num_labels,
  output logic [LBL_WIDTH-1:0] obj_id,
  input  logic [LOC_SIZE-1:0]  obj_area,
  input  logic [LOC_SIZE-1:0]  obj_x,
  input  logic [LOC_SIZE-1:0]  obj_y,
  input  logic [LOC_SIZE-1:0]  obj_m02,
  input  logic [LOC_SIZE-1:0]  obj_m11,
  input  logic [LOC_SIZE-1:0]  obj_m20,
  input  logic [LOC_SIZE-1:0]  obj_m30,
  input  logic [LOC_SIZE-1:0]  obj_m21,
  input  logic [LOC_SIZE-1:0]  obj_m12,
  input  logic [LOC_SIZE-1:0]  obj_m03,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOC_SIZE-1:0]  out_data,
  output logic [LBL_WIDTH-1:0] out_label,
  output logic [3:0]           out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SEND, FINISH} state_t;

  localparam logic [3:0]           LAT = 4'(READ_LATENCY);
  localparam logic [LBL_WIDTH-1:0] ONE = LBL_WIDTH'(1);

  state_t               state, state_next;
  logic [LBL_WIDTH-1:0] n_max, id_reg, label_reg;
  logic [3:0]           wait_cnt, index_reg;
  logic                 valid_reg, busy_reg;
  logic [LOC_SIZE-1:0]  shadow  [10];
  logic [LOC_SIZE-1:0]  stat_in [10];
  logic                 accept_start, do_capture, advance, rec_done;
  logic                 last_label, skip_rec;

  assign stat_in[0] = obj_area;
  assign stat_in[1] = obj_x;
  assign stat_in[2] = obj_y;
  assign stat_in[3] = obj_m02;
  assign stat_in[4] = obj_m11;
  assign stat_in[5] = obj_m20;
  assign stat_in[6] = obj_m30;
  assign stat_in[7] = obj_m21;
  assign stat_in[8] = obj_m12;
  assign stat_in[9] = obj_m03;

  // Equality against n_max means a full-range scan ends at the top label without wrapping.
  assign last_label = (id_reg == n_max);
  assign skip_rec   = (SKIP_EMPTY != 0) && (obj_area == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    do_capture   = 1'b0;
    advance      = 1'b0;
    rec_done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = (num_labels == '0) ? FINISH : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) state_next = CAPTURE;
      end
      CAPTURE: begin
        do_capture = 1'b1;
        if (skip_rec) rec_done   = 1'b1;
        else          state_next = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (index_reg == 4'd9) rec_done = 1'b1;
          else                   advance  = 1'b1;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rec_done) state_next = last_label ? FINISH : WAIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_max     <= '0;
      id_reg    <= '0;
      label_reg <= '0;
      wait_cnt  <= '0;
      index_reg <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      for (int i = 0; i < 10; i++) shadow[i] <= '0;
    end else begin
      if (accept_start) begin
        n_max <= num_labels;
        if (num_labels != '0) begin
          id_reg   <= ONE;
          busy_reg <= 1'b1;
          wait_cnt <= LAT;
        end
      end
      if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
      // Snapshot so the stream no longer depends on obj_id or the live inputs.
      if (do_capture) begin
        for (int i = 0; i < 10; i++) shadow[i] <= stat_in[i];
        label_reg <= id_reg;
        index_reg <= '0;
      end
      if (advance) index_reg <= index_reg + 4'd1;
      if (rec_done && !last_label) begin
        id_reg   <= id_reg + ONE;
        wait_cnt <= LAT;
      end
      valid_reg <= (state_next == SEND);
      if (state == FINISH) busy_reg <= 1'b0;
    end
  end

  assign obj_id    = id_reg;
  assign out_valid = valid_reg;
  assign out_data  = valid_reg ? shadow[index_reg] : '0;
  assign out_label = label_reg;
  assign out_index = index_reg;
  assign out_last  = valid_reg && (index_reg == 4'd9);
  assign busy      = busy_reg;
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_object_stats_reader.sv
// Bench for object_stats_reader: two instances (latency 2 with skipping, latency 5 without),
// a delayed statistics model and a queue-based expected stream per scan.
module tb_object_stats_reader;
  localparam int LW = 8;
  localparam int LS = 16;
  localparam int RL0 = 2;
  localparam int RL1 = 5;

  typedef struct packed {
    logic       u;
    logic [7:0] label;
    logic [3:0] idx;
    logic [15:0] data;
    logic       last;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start [2];
  logic [LW-1:0] num_labels [2];
  logic [LW-1:0] obj_id [2];
  logic [LS-1:0] stat [2][10];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [LS-1:0] out_data [2];
  logic [LW-1:0] out_label [2];
  logic [3:0]    out_index [2];
  logic          out_last [2];
  logic          busy [2];
  logic          done [2];

  object_stats_reader #(.LBL_WIDTH(LW), .LOC_SIZE(LS), .READ_LATENCY(RL0), .SKIP_EMPTY(1)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .num_labels(num_labels[0]), .obj_id(obj_id[0]),
    .obj_area(stat[0][0]), .obj_x(stat[0][1]), .obj_y(stat[0][2]), .obj_m02(stat[0][3]),
    .obj_m11(stat[0][4]), .obj_m20(stat[0][5]), .obj_m30(stat[0][6]), .obj_m21(stat[0][7]),
    .obj_m12(stat[0][8]), .obj_m03(stat[0][9]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_label(out_label[0]), .out_index(out_index[0]),
    .out_last(out_last[0]), .busy(busy[0]), .done(done[0]));

  object_stats_reader #(.LBL_WIDTH(LW), .LOC_SIZE(LS), .READ_LATENCY(RL1), .SKIP_EMPTY(0)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .num_labels(num_labels[1]), .obj_id(obj_id[1]),
    .obj_area(stat[1][0]), .obj_x(stat[1][1]), .obj_y(stat[1][2]), .obj_m02(stat[1][3]),
    .obj_m11(stat[1][4]), .obj_m20(stat[1][5]), .obj_m30(stat[1][6]), .obj_m21(stat[1][7]),
    .obj_m12(stat[1][8]), .obj_m03(stat[1][9]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_label(out_label[1]), .out_index(out_index[1]),
    .out_last(out_last[1]), .busy(busy[1]), .done(done[1]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int unsigned salt [2];
  bit empty [2][256];
  logic [7:0] dly [2][16];
  rec_t got[$];
  int done_cnt [2], done_cyc [2], hs_cyc [2], valid_cnt [2], stall_err [2];
  bit busy_seen [2];
  logic pv [2], pr [2], plast [2];
  logic [15:0] pd [2];
  logic [7:0] pl [2];
  logic [3:0] pi [2];

  function automatic logic [15:0] word(input int u, input int id, input int k);
    if (k == 0) return empty[u][id] ? 16'd0 : 16'(10 * id + (salt[u] % 256));
    return 16'(id + k + int'(salt[u]));
  endfunction

  function automatic logic [39:0] outs(input int u);
    return {obj_id[u], out_valid[u], out_data[u], out_label[u], out_index[u],
            out_last[u], busy[u], done[u]};
  endfunction

  // Statistics become valid READ_LATENCY cycles after obj_id changes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < 2; u++) begin
      for (int i = 15; i > 0; i--) dly[u][i] <= dly[u][i-1];
      dly[u][0] <= obj_id[u];
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int sid;
      sid = int'(dly[u][((u == 0) ? RL0 : RL1) - 1]);
      for (int k = 0; k < 10; k++) stat[u][k] = word(u, sid, k);
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (out_valid[u] && out_ready[u]) begin
        rec_t r;
        r.u = 1'(u); r.label = out_label[u]; r.idx = out_index[u];
        r.data = out_data[u]; r.last = out_last[u];
        got.push_back(r);
        hs_cyc[u] = cyc;
      end
      if (out_valid[u]) valid_cnt[u]++;
      if (busy[u]) busy_seen[u] = 1'b1;
      if (done[u]) begin done_cnt[u]++; done_cyc[u] = cyc; end
      if (pv[u] && !pr[u] && !(out_valid[u] && out_data[u] == pd[u] && out_index[u] == pi[u] &&
                               out_label[u] == pl[u] && out_last[u] == plast[u]))
        stall_err[u]++;
      pv[u] = out_valid[u]; pr[u] = out_ready[u]; pd[u] = out_data[u];
      pi[u] = out_index[u]; pl[u] = out_label[u]; plast[u] = out_last[u];
    end
  end

  task automatic clear_mon(input int u);
    got.delete();
    done_cnt[u] = 0; done_cyc[u] = -1; hs_cyc[u] = -1; valid_cnt[u] = 0;
    stall_err[u] = 0; busy_seen[u] = 1'b0; pv[u] = 1'b0;
  endtask

  task automatic run_scan(input string name, input int u, input int n, input int mode, input int mid_start);
    rec_t exp[$];
    rec_t r;
    int st_cyc, c, expd;
    clear_mon(u);
    for (int id = 1; id <= n; id++)
      for (int k = 0; k < 10; k++)
        if (!(u == 0 && empty[u][id])) begin
          r.u = 1'(u); r.label = 8'(id); r.idx = 4'(k); r.data = word(u, id, k); r.last = (k == 9);
          exp.push_back(r);
        end
    @(posedge clk); #1;
    num_labels[u] = 8'(n); start[u] = 1'b1; out_ready[u] = 1'b1; st_cyc = cyc;
    c = 0;
    while (done_cnt[u] == 0 && c < 20000) begin
      @(posedge clk); #1;
      c++;
      start[u] = (mid_start != 0 && c == mid_start);
      num_labels[u] = start[u] ? 8'(n + 1) : 8'($urandom);
      out_ready[u] = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
    end
    start[u] = 1'b0;
    out_ready[u] = 1'b1;
    repeat (4) @(posedge clk);
    #1 out_ready[u] = 1'b0;
    checks++;
    if (done_cnt[u] == 0) begin failures++; $display("FAIL %s_timeout: no done after %0d cycles", name, c); end
    checks++;
    if (got.size() != exp.size()) begin
      failures++; $display("FAIL %s_count: got %0d words, expected %0d", name, got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL %s_word%0d: got lbl=%0d idx=%0d data=%h last=%0d, expected lbl=%0d idx=%0d data=%h last=%0d",
                 name, i, got[i].label, got[i].idx, got[i].data, got[i].last,
                 exp[i].label, exp[i].idx, exp[i].data, exp[i].last);
      end
    end
    checks++;
    if (stall_err[u] != 0) begin failures++; $display("FAIL %s_stall: %0d unstable stalls, expected 0", name, stall_err[u]); end
    checks++;
    if (done_cnt[u] != 1) begin failures++; $display("FAIL %s_done_count: got %0d, expected 1", name, done_cnt[u]); end
    expd = -1;
    if (n == 0) expd = st_cyc + 1;
    else if (exp.size() > 0 && int'(exp[exp.size()-1].label) == n) expd = hs_cyc[u] + 1;
    if (expd >= 0) begin
      checks++;
      if (done_cyc[u] != expd) begin
        failures++; $display("FAIL %s_done_time: done at cycle %0d, expected %0d", name, done_cyc[u], expd);
      end
    end
    if (n == 0) begin
      checks++;
      if (busy_seen[u] || valid_cnt[u] != 0) begin
        failures++; $display("FAIL %s_idle: busy_seen=%0d valid_cycles=%0d, expected 0 and 0", name, busy_seen[u], valid_cnt[u]);
      end
    end
  endtask

  task automatic set_model(input int u, input int unsigned s, input int pct_empty);
    salt[u] = s;
    for (int i = 0; i < 256; i++) empty[u][i] = ($urandom_range(0, 99) < pct_empty);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (outs(u) !== 40'd0) begin failures++; $display("FAIL reset_u%0d: outputs %h, expected 0", u, outs(u)); end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (outs(u) !== 40'd0) begin failures++; $display("FAIL reset_idle_u%0d: outputs %h, expected 0", u, outs(u)); end
    end
  endtask

  task automatic test_basic();
    set_model(0, 0, 0);
    run_scan("basic", 0, 2, 0, 0);
    if (got.size() >= 20) begin
      checks++;
      if (got[0].data !== 16'd10 || got[10].data !== 16'd20) begin
        failures++; $display("FAIL basic_area: got %0d,%0d expected 10,20", got[0].data, got[10].data);
      end
      checks++;
      if (!got[9].last || !got[19].last || got[8].last) begin
        failures++; $display("FAIL basic_last: w8=%0d w9=%0d w19=%0d expected 0,1,1", got[8].last, got[9].last, got[19].last);
      end
    end
  endtask

  task automatic test_backpressure();
    set_model(0, $urandom, 0);
    run_scan("bp_pattern", 0, 4, 1, 0);
    set_model(0, $urandom, 20);
    run_scan("bp_random", 0, $urandom_range(1, 6), 2, 0);
  endtask

  task automatic test_skip_empty();
    for (int u = 0; u < 2; u++) begin
      set_model(u, $urandom, 0);
      empty[u][2] = 1'b1;
    end
    run_scan("skip_on", 0, 3, 0, 0);
    run_scan("skip_off", 1, 3, 0, 0);
    if (got.size() >= 11) begin
      checks++;
      if (got[10].label !== 8'd2 || got[10].data !== 16'd0) begin
        failures++; $display("FAIL skip_off_area: got lbl=%0d data=%0d expected lbl=2 data=0", got[10].label, got[10].data);
      end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    set_model(0, $urandom, 0);
    run_scan("zero_labels", 0, 0, 0, 0);
    run_scan("ignored_start", 0, 3, 0, 5);
  endtask

  task automatic test_latency();
    set_model(1, $urandom, 25);
    run_scan("latency5", 1, 4, 2, 0);
  endtask

  task automatic test_max_labels();
    set_model(0, $urandom, 100);
    empty[0][1] = 1'b0; empty[0][128] = 1'b0; empty[0][255] = 1'b0;
    run_scan("max_labels", 0, 255, 0, 0);
  endtask

  task automatic test_reset_mid_record();
    int c;
    set_model(0, $urandom, 0);
    clear_mon(0);
    @(posedge clk); #1;
    num_labels[0] = 8'd2; start[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    c = 0;
    while (got.size() < 5 && c < 500) begin @(negedge clk); #1; c++; end
    checks++;
    if (got.size() < 5) begin failures++; $display("FAIL midreset_timeout: %0d words, expected 5", got.size()); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (outs(0) !== 40'd0) begin failures++; $display("FAIL midreset_outputs: %h, expected 0", outs(0)); end
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (done_cnt[0] != 0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL midreset_no_done: done_cnt=%0d busy=%0d expected 0,0", done_cnt[0], busy[0]);
    end
    out_ready[0] = 1'b0;
    run_scan("rescan", 0, 2, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      set_model(t % 2, $urandom, 30);
      run_scan("random", t % 2, $urandom_range(1, 6), $urandom_range(0, 2), 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; num_labels[u] = '0; out_ready[u] = 1'b0; salt[u] = 0;
      for (int i = 0; i < 16; i++) dly[u][i] = '0;
      for (int i = 0; i < 256; i++) empty[u][i] = 1'b0;
      clear_mon(u);
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_skip_empty();
    test_zero_and_ignored_start();
    test_latency();
    test_max_labels();
    test_reset_mid_record();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
